// File: rtl/alu_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_resp_checker
// Purpose  : Golden-model response checker for the ALU interface; counts
//            checks/mismatches, captures the first failing beat, can halt.
// Revision : 1.0  initial release
// ============================================================================
module alu_resp_checker #(
    parameter int BUS_WIDTH    = 8,
    parameter int CNT_WIDTH    = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic [BUS_WIDTH-1:0] y,
    input  logic                 carry_out,
    input  logic                 borrow,
    input  logic                 zero,
    input  logic                 parity,
    input  logic                 invalid_op,
    output logic                 err_pulse,
    output logic                 fail,
    output logic [CNT_WIDTH-1:0] check_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [3:0]           ff_opcode,
    output logic [BUS_WIDTH-1:0] ff_a,
    output logic [BUS_WIDTH-1:0] ff_b,
    output logic [BUS_WIDTH-1:0] ff_y,
    output logic [BUS_WIDTH-1:0] ff_exp_y
);

    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_ADDC = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd3;
    localparam logic [3:0] c_OP_INC  = 4'd4;
    localparam logic [3:0] c_OP_DEC  = 4'd5;
    localparam logic [3:0] c_OP_AND  = 4'd6;
    localparam logic [3:0] c_OP_NOT  = 4'd7;
    localparam logic [3:0] c_OP_ROL  = 4'd8;
    localparam logic [3:0] c_OP_ROR  = 4'd9;

    localparam logic [BUS_WIDTH:0]   c_ONE_EXT = 1;
    localparam logic [BUS_WIDTH-1:0] c_ONE     = 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_started;
    logic                 w_accept;

    logic                 r_s1_valid;
    logic [3:0]           r_s1_opcode;
    logic [BUS_WIDTH-1:0] r_s1_a;
    logic [BUS_WIDTH-1:0] r_s1_b;
    logic                 r_s1_cin;
    logic [BUS_WIDTH-1:0] r_s1_y;
    logic                 r_s1_co;
    logic                 r_s1_bo;
    logic                 r_s1_zero;
    logic                 r_s1_par;
    logic                 r_s1_inv;

    logic [BUS_WIDTH:0]   w_sum;
    logic [BUS_WIDTH-1:0] w_exp_y;
    logic                 w_exp_co;
    logic                 w_exp_bo;
    logic                 w_exp_inv;
    logic                 w_exp_zero;
    logic                 w_exp_par;
    logic                 w_mismatch;

    logic                 r_err_pulse;
    logic                 r_fail;
    logic [CNT_WIDTH-1:0] r_check_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [3:0]           r_ff_opcode;
    logic [BUS_WIDTH-1:0] r_ff_a;
    logic [BUS_WIDTH-1:0] r_ff_b;
    logic [BUS_WIDTH-1:0] r_ff_y;
    logic [BUS_WIDTH-1:0] r_ff_exp_y;

    // in_ready is held low until the first edge after reset release.
    assign in_ready = r_started && (r_state == ST_RUN);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_opcode <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_cin    <= 1'b0;
            r_s1_y      <= '0;
            r_s1_co     <= 1'b0;
            r_s1_bo     <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_par    <= 1'b0;
            r_s1_inv    <= 1'b0;
        end else if (clear) begin
            r_s1_valid  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_opcode <= opcode;
                r_s1_a      <= a;
                r_s1_b      <= b;
                r_s1_cin    <= carry_in;
                r_s1_y      <= y;
                r_s1_co     <= carry_out;
                r_s1_bo     <= borrow;
                r_s1_zero   <= zero;
                r_s1_par    <= parity;
                r_s1_inv    <= invalid_op;
            end
        end
    end

    // Golden model, evaluated on the S1 beat.
    always_comb begin
        w_sum     = '0;
        w_exp_y   = '0;
        w_exp_co  = 1'b0;
        w_exp_bo  = 1'b0;
        w_exp_inv = 1'b0;
        case (r_s1_opcode)
            c_OP_ADD: begin
                w_sum    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
                w_exp_y  = w_sum[BUS_WIDTH-1:0];
                w_exp_co = w_sum[BUS_WIDTH];
            end
            c_OP_ADDC: begin
                w_sum    = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{BUS_WIDTH{1'b0}}, r_s1_cin};
                w_exp_y  = w_sum[BUS_WIDTH-1:0];
                w_exp_co = w_sum[BUS_WIDTH];
            end
            c_OP_SUB: begin
                w_exp_y  = r_s1_a - r_s1_b;
                w_exp_bo = (r_s1_a < r_s1_b);
            end
            c_OP_INC: begin
                w_sum    = {1'b0, r_s1_a} + c_ONE_EXT;
                w_exp_y  = w_sum[BUS_WIDTH-1:0];
                w_exp_co = w_sum[BUS_WIDTH];
            end
            c_OP_DEC: begin
                w_exp_y  = r_s1_a - c_ONE;
                w_exp_bo = (r_s1_a == '0);
            end
            c_OP_AND: w_exp_y = r_s1_a & r_s1_b;
            c_OP_NOT: w_exp_y = ~r_s1_a;
            c_OP_ROL: w_exp_y = {r_s1_a[BUS_WIDTH-2:0], r_s1_a[BUS_WIDTH-1]};
            c_OP_ROR: w_exp_y = {r_s1_a[0], r_s1_a[BUS_WIDTH-1:1]};
            default:  w_exp_inv = 1'b1;
        endcase
    end

    assign w_exp_zero = (w_exp_y == '0);
    assign w_exp_par  = ^w_exp_y;

    assign w_mismatch = r_s1_valid &&
                        ((r_s1_y    != w_exp_y)    ||
                         (r_s1_co   != w_exp_co)   ||
                         (r_s1_bo   != w_exp_bo)   ||
                         (r_s1_zero != w_exp_zero) ||
                         (r_s1_par  != w_exp_par)  ||
                         (r_s1_inv  != w_exp_inv));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pulse <= 1'b0;
            r_fail      <= 1'b0;
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_ff_opcode <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_y      <= '0;
            r_ff_exp_y  <= '0;
        end else if (clear) begin
            r_err_pulse <= 1'b0;
            r_fail      <= 1'b0;
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_ff_opcode <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_y      <= '0;
            r_ff_exp_y  <= '0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (r_s1_valid && (r_check_cnt != c_CNT_MAX)) begin
                r_check_cnt <= r_check_cnt + c_CNT_ONE;
            end
            if (w_mismatch) begin
                r_fail <= 1'b1;
                if (r_err_cnt != c_CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + c_CNT_ONE;
                end
                // Only the first mismatch since reset/clear is captured.
                if (!r_fail) begin
                    r_ff_opcode <= r_s1_opcode;
                    r_ff_a      <= r_s1_a;
                    r_ff_b      <= r_s1_b;
                    r_ff_y      <= r_s1_y;
                    r_ff_exp_y  <= w_exp_y;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_RUN;
        end else if ((r_state == ST_RUN) && STOP_ON_FAIL && w_mismatch) begin
            w_state_nxt = ST_HALT;
        end
    end

    assign err_pulse = r_err_pulse;
    assign fail      = r_fail;
    assign check_cnt = r_check_cnt;
    assign err_cnt   = r_err_cnt;
    assign ff_opcode = r_ff_opcode;
    assign ff_a      = r_ff_a;
    assign ff_b      = r_ff_b;
    assign ff_y      = r_ff_y;
    assign ff_exp_y  = r_ff_exp_y;

endmodule
`default_nettype wire

// File: tb/tb_alu_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_resp_checker
// Purpose  : Self-checking bench for alu_resp_checker (three parameter sets).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_resp_checker;

    localparam int W = 8;
    localparam int M = 1 << W;

    typedef struct packed {
        logic [W-1:0] y;
        logic         co;
        logic         bo;
        logic         z;
        logic         p;
        logic         inv;
    } resp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   opcode = '0;
    logic [W-1:0] a = '0, b = '0, y = '0;
    logic         carry_in = 1'b0, carry_out = 1'b0, borrow = 1'b0;
    logic         zero = 1'b0, parity = 1'b0, invalid_op = 1'b0;

    logic         da_in_ready, da_err_pulse, da_fail;
    logic [15:0]  da_check_cnt, da_err_cnt;
    logic [3:0]   da_ff_opcode;
    logic [W-1:0] da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y;

    logic         ds_in_ready, ds_err_pulse, ds_fail;
    logic [15:0]  ds_check_cnt, ds_err_cnt;
    logic [3:0]   ds_ff_opcode;
    logic [W-1:0] ds_ff_a, ds_ff_b, ds_ff_y, ds_ff_exp_y;

    logic         dc_in_ready, dc_err_pulse, dc_fail;
    logic [3:0]   dc_check_cnt, dc_err_cnt;
    logic [3:0]   dc_ff_opcode;
    logic [W-1:0] dc_ff_a, dc_ff_b, dc_ff_y, dc_ff_exp_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_resp_checker #(.BUS_WIDTH(W), .CNT_WIDTH(16), .STOP_ON_FAIL(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(da_in_ready),
        .opcode(opcode), .a(a), .b(b), .carry_in(carry_in), .y(y), .carry_out(carry_out),
        .borrow(borrow), .zero(zero), .parity(parity), .invalid_op(invalid_op),
        .err_pulse(da_err_pulse), .fail(da_fail), .check_cnt(da_check_cnt), .err_cnt(da_err_cnt),
        .ff_opcode(da_ff_opcode), .ff_a(da_ff_a), .ff_b(da_ff_b), .ff_y(da_ff_y), .ff_exp_y(da_ff_exp_y)
    );

    alu_resp_checker #(.BUS_WIDTH(W), .CNT_WIDTH(16), .STOP_ON_FAIL(1'b1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(ds_in_ready),
        .opcode(opcode), .a(a), .b(b), .carry_in(carry_in), .y(y), .carry_out(carry_out),
        .borrow(borrow), .zero(zero), .parity(parity), .invalid_op(invalid_op),
        .err_pulse(ds_err_pulse), .fail(ds_fail), .check_cnt(ds_check_cnt), .err_cnt(ds_err_cnt),
        .ff_opcode(ds_ff_opcode), .ff_a(ds_ff_a), .ff_b(ds_ff_b), .ff_y(ds_ff_y), .ff_exp_y(ds_ff_exp_y)
    );

    alu_resp_checker #(.BUS_WIDTH(W), .CNT_WIDTH(4), .STOP_ON_FAIL(1'b0)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(dc_in_ready),
        .opcode(opcode), .a(a), .b(b), .carry_in(carry_in), .y(y), .carry_out(carry_out),
        .borrow(borrow), .zero(zero), .parity(parity), .invalid_op(invalid_op),
        .err_pulse(dc_err_pulse), .fail(dc_fail), .check_cnt(dc_check_cnt), .err_cnt(dc_err_cnt),
        .ff_opcode(dc_ff_opcode), .ff_a(dc_ff_a), .ff_b(dc_ff_b), .ff_y(dc_ff_y), .ff_exp_y(dc_ff_exp_y)
    );

    // Reference ALU response from plain integer arithmetic.
    function automatic resp_t golden(input int op, input int ia, input int ib, input int ci);
        resp_t r;
        int    v;
        r = '0;
        v = 0;
        case (op)
            1: begin v = ia + ib;      r.co = (v >= M); v = v % M; end
            2: begin v = ia + ib + ci; r.co = (v >= M); v = v % M; end
            3: begin r.bo = (ia < ib);  v = (ia - ib + M) % M; end
            4: begin r.co = (ia == M - 1); v = (ia + 1) % M; end
            5: begin r.bo = (ia == 0);  v = (ia - 1 + M) % M; end
            6: v = ia & ib;
            7: v = (M - 1) - ia;
            8: v = (ia * 2) % M + ia / (M / 2);
            9: v = ia / 2 + (ia % 2) * (M / 2);
            default: begin r.inv = 1'b1; v = 0; end
        endcase
        r.y = v[W-1:0];
        r.z = (v == 0);
        r.p = (($countones(r.y) % 2) == 1);
        return r;
    endfunction

    task automatic drive_beat(input int op, input int ia, input int ib, input int ci, input resp_t rsp);
        in_valid   = 1'b1;
        opcode     = op[3:0];
        a          = ia[W-1:0];
        b          = ib[W-1:0];
        carry_in   = ci[0];
        y          = rsp.y;
        carry_out  = rsp.co;
        borrow     = rsp.bo;
        zero       = rsp.z;
        parity     = rsp.p;
        invalid_op = rsp.inv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({da_in_ready, da_check_cnt, da_err_cnt, da_fail, da_err_pulse} !== '0) begin
            errors++;
            $display("FAIL reset_state got ready=%0b chk=%0d err=%0d fail=%0b pulse=%0b want all 0",
                     da_in_ready, da_check_cnt, da_err_cnt, da_fail, da_err_pulse);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if ({da_in_ready, ds_in_ready, dc_in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 000", {da_in_ready, ds_in_ready, dc_in_ready});
        end
        tick();
        checks++;
        if ({da_in_ready, ds_in_ready, dc_in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_release got %b want 111", {da_in_ready, ds_in_ready, dc_in_ready});
        end
        checks++;
        if ({da_check_cnt, da_err_cnt, da_fail} !== '0) begin
            errors++;
            $display("FAIL idle_counts got chk=%0d err=%0d fail=%0b want 0 0 0", da_check_cnt, da_err_cnt, da_fail);
        end
    endtask

    task automatic test_directed();
        int ops[12] = '{1, 2, 3, 3, 4, 5, 6, 7, 8, 9, 0, 12};
        int as[12]  = '{9, 9, 65, 65, 233, 1, 2, 'hFE, 'h01, 'h80, 5, 7};
        int bs[12]  = '{33, 33, 64, 66, 0, 0, 3, 0, 0, 0, 3, 4};
        int cs[12]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_clear();
        for (int i = 0; i < 12; i++) begin
            drive_beat(ops[i], as[i], bs[i], cs[i], golden(ops[i], as[i], bs[i], cs[i]));
            tick();
            checks++;
            if (da_err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL directed_pulse beat=%0d got 1 want 0", i);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({da_check_cnt, da_err_cnt, da_fail} !== {16'd12, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL directed_counts got chk=%0d err=%0d fail=%0b want 12 0 0", da_check_cnt, da_err_cnt, da_fail);
        end
    endtask

    task automatic test_fault();
        resp_t rsp;
        do_clear();
        rsp = golden(1, 9, 33, 0);
        rsp.y = 8'd43;
        drive_beat(1, 9, 33, 0, rsp);
        tick();
        in_valid = 1'b0;
        checks++;
        if (da_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL fault_pulse_early got 1 want 0");
        end
        tick();
        checks++;
        if (da_err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL fault_pulse got 0 want 1");
        end
        tick();
        checks++;
        if (da_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL fault_pulse_width got 1 want 0");
        end
        checks++;
        if ({da_err_cnt, da_fail, da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y} !==
            {16'd1, 1'b1, 4'd1, 8'd9, 8'd33, 8'd43, 8'd42}) begin
            errors++;
            $display("FAIL first_fail got err=%0d fail=%0b op=%0d a=%0d b=%0d y=%0d ey=%0d want 1 1 1 9 33 43 42",
                     da_err_cnt, da_fail, da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y);
        end
        rsp = golden(4, 255, 0, 0);
        rsp.co = 1'b0;
        drive_beat(4, 255, 0, 0, rsp);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (da_err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL second_fault_pulse got 0 want 1");
        end
        checks++;
        if ({da_check_cnt, da_err_cnt, da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y} !==
            {16'd2, 16'd2, 4'd1, 8'd9, 8'd33, 8'd43, 8'd42}) begin
            errors++;
            $display("FAIL second_fault got chk=%0d err=%0d op=%0d a=%0d b=%0d y=%0d ey=%0d want 2 2 1 9 33 43 42",
                     da_check_cnt, da_err_cnt, da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y);
        end
    endtask

    task automatic test_reset_mid();
        drive_beat(6, 2, 3, 0, golden(6, 2, 3, 0));
        tick();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({da_in_ready, da_check_cnt, da_err_cnt, da_fail, da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y} !== '0) begin
            errors++;
            $display("FAIL async_reset got ready=%0b chk=%0d err=%0d fail=%0b ffa=%0d want all 0",
                     da_in_ready, da_check_cnt, da_err_cnt, da_fail, da_ff_a);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({da_in_ready, da_check_cnt, da_err_cnt} !== {1'b1, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_drop got ready=%0b chk=%0d err=%0d want 1 0 0", da_in_ready, da_check_cnt, da_err_cnt);
        end
    endtask

    task automatic test_stop_on_fail();
        resp_t rsp;
        do_clear();
        rsp = golden(1, 9, 33, 0);
        rsp.y = 8'd43;
        drive_beat(1, 9, 33, 0, rsp);
        tick();
        checks++;
        if (ds_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stop_ready_before got 0 want 1");
        end
        drive_beat(6, 5, 3, 0, golden(6, 5, 3, 0));
        tick();
        checks++;
        if ({ds_in_ready, ds_fail, ds_err_pulse} !== 3'b011) begin
            errors++;
            $display("FAIL stop_halt got ready=%0b fail=%0b pulse=%0b want 0 1 1", ds_in_ready, ds_fail, ds_err_pulse);
        end
        for (int i = 0; i < 6; i++) begin
            drive_beat(7, i, 0, 0, golden(7, i, 0, 0));
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({ds_in_ready, ds_check_cnt, ds_err_cnt, ds_ff_y, ds_ff_exp_y} !== {1'b0, 16'd2, 16'd1, 8'd43, 8'd42}) begin
            errors++;
            $display("FAIL stop_counts got ready=%0b chk=%0d err=%0d ffy=%0d ffey=%0d want 0 2 1 43 42",
                     ds_in_ready, ds_check_cnt, ds_err_cnt, ds_ff_y, ds_ff_exp_y);
        end
        do_clear();
        checks++;
        if ({ds_in_ready, ds_check_cnt, ds_err_cnt, ds_fail} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL stop_clear got ready=%0b chk=%0d err=%0d fail=%0b want 1 0 0 0",
                     ds_in_ready, ds_check_cnt, ds_err_cnt, ds_fail);
        end
    endtask

    task automatic test_clear_collision();
        resp_t rsp;
        do_clear();
        rsp = golden(1, 1, 1, 0);
        rsp.y = 8'd0;
        drive_beat(1, 1, 1, 0, rsp);
        tick();
        clear = 1'b1;
        drive_beat(1, 1, 1, 0, rsp);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (da_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse got 1 want 0");
        end
        tick();
        tick();
        checks++;
        if ({da_check_cnt, da_err_cnt, da_fail, da_err_pulse} !== '0) begin
            errors++;
            $display("FAIL clear_collision got chk=%0d err=%0d fail=%0b pulse=%0b want 0 0 0 0",
                     da_check_cnt, da_err_cnt, da_fail, da_err_pulse);
        end
    endtask

    task automatic test_saturate();
        resp_t rsp;
        do_clear();
        rsp = golden(1, 1, 1, 0);
        rsp.y = 8'd0;
        for (int i = 0; i < 20; i++) begin
            drive_beat(1, 1, 1, 0, rsp);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({dc_check_cnt, dc_err_cnt, dc_fail, dc_in_ready} !== {4'd15, 4'd15, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL saturate got chk=%0d err=%0d fail=%0b ready=%0b want 15 15 1 1",
                     dc_check_cnt, dc_err_cnt, dc_fail, dc_in_ready);
        end
        checks++;
        if ({dc_ff_opcode, dc_ff_a, dc_ff_b, dc_ff_y, dc_ff_exp_y, dc_err_pulse} !== {4'd1, 8'd1, 8'd1, 8'd0, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL saturate_ff got op=%0d a=%0d b=%0d y=%0d ey=%0d pulse=%0b want 1 1 1 0 2 0",
                     dc_ff_opcode, dc_ff_a, dc_ff_b, dc_ff_y, dc_ff_exp_y, dc_err_pulse);
        end
    endtask

    task automatic test_random();
        resp_t        rsp, good;
        logic [12:0]  mask;
        int           exp_chk, exp_err, op, ia, ib, ci;
        bit           v, fault, pend_v, pend_f, got_first;
        logic [3:0]   p_op, e_op;
        logic [W-1:0] p_a, p_b, p_y, p_ey, e_a, e_b, e_y, e_ey;
        exp_chk = 0; exp_err = 0; pend_v = 0; pend_f = 0; got_first = 0;
        p_op = '0; p_a = '0; p_b = '0; p_y = '0; p_ey = '0;
        e_op = '0; e_a = '0; e_b = '0; e_y = '0; e_ey = '0;
        do_clear();
        for (int i = 0; i <= 300; i++) begin
            v     = (i < 300) && ($urandom_range(0, 3) != 0);
            op    = $urandom_range(0, 15);
            ia    = $urandom_range(0, M - 1);
            ib    = $urandom_range(0, M - 1);
            ci    = $urandom_range(0, 1);
            good  = golden(op, ia, ib, ci);
            rsp   = good;
            fault = v && ($urandom_range(0, 3) == 0);
            if (fault) begin
                mask = 13'($urandom_range(1, 8191));
                rsp  = rsp ^ mask;
            end
            drive_beat(op, ia, ib, ci, rsp);
            in_valid = v;
            tick();
            checks++;
            if (da_err_pulse !== (pend_v && pend_f)) begin
                errors++;
                $display("FAIL random_pulse cycle=%0d got %0b want %0b", i, da_err_pulse, pend_v && pend_f);
            end
            if (pend_v) begin
                exp_chk++;
                if (pend_f) begin
                    exp_err++;
                    if (!got_first) begin
                        got_first = 1;
                        e_op = p_op; e_a = p_a; e_b = p_b; e_y = p_y; e_ey = p_ey;
                    end
                end
            end
            pend_v = v; pend_f = fault;
            p_op = op[3:0]; p_a = ia[W-1:0]; p_b = ib[W-1:0]; p_y = rsp.y; p_ey = good.y;
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({da_check_cnt, da_err_cnt, da_fail} !== {16'(exp_chk), 16'(exp_err), got_first}) begin
            errors++;
            $display("FAIL random_counts got chk=%0d err=%0d fail=%0b want %0d %0d %0b",
                     da_check_cnt, da_err_cnt, da_fail, exp_chk, exp_err, got_first);
        end
        checks++;
        if ({da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y} !== {e_op, e_a, e_b, e_y, e_ey}) begin
            errors++;
            $display("FAIL random_first_fail got op=%0d a=%0d b=%0d y=%0d ey=%0d want %0d %0d %0d %0d %0d",
                     da_ff_opcode, da_ff_a, da_ff_b, da_ff_y, da_ff_exp_y, e_op, e_a, e_b, e_y, e_ey);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fault();
        test_reset_mid();
        test_stop_on_fail();
        test_clear_collision();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
